// File: rtl/rr_arbiter_8_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter_8_if : request/grant bundle for the 8-way round-robin arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
interface rr_arbiter_8_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic       busy;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  grant,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output busy,
    output timeout
  );
endinterface

`default_nettype wire

// File: rtl/rr_arbiter_8.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter_8 : 8-way round-robin arbiter with registered one-hot grant
//                and a bounded hold time that forces release on expiry.
// Revision: 1.0
// ---------------------------------------------------------------------------
module rr_arbiter_8 #(
  parameter int MAX_HOLD = 16
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  rr_arbiter_8_if.slave  bus
);

  localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [7:0]     r_grant;
  logic [7:0]     w_grant_nxt;
  logic [2:0]     r_ptr;
  logic [2:0]     w_ptr_nxt;
  logic [2:0]     r_idx;
  logic [2:0]     w_idx_nxt;
  logic [HW-1:0]  r_hcnt;
  logic [HW-1:0]  w_hcnt_nxt;
  logic           r_timeout;
  logic           w_timeout_nxt;

  logic [2:0]     w_sel;
  logic [2:0]     w_cand;
  logic           w_found;
  logic           w_rel_done;
  logic           w_rel_req;
  logic           w_rel_max;

  // Circular priority search starting at r_ptr.
  always_comb begin
    w_sel   = 3'd0;
    w_cand  = 3'd0;
    w_found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      w_cand = r_ptr + 3'(k);
      if (!w_found && bus.req[w_cand]) begin
        w_sel   = w_cand;
        w_found = 1'b1;
      end
    end
  end

  assign w_rel_done = bus.done;
  assign w_rel_req  = ~bus.req[r_idx];
  assign w_rel_max  = (r_hcnt == HW'(MAX_HOLD - 1));

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_ptr_nxt     = r_ptr;
    w_idx_nxt     = r_idx;
    w_hcnt_nxt    = r_hcnt;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant_nxt = 8'b1 << w_sel;
          w_idx_nxt   = w_sel;
          w_hcnt_nxt  = '0;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_rel_done || w_rel_req || w_rel_max) begin
          w_grant_nxt   = 8'h00;
          w_ptr_nxt     = r_idx + 3'd1;
          w_state_nxt   = S_IDLE;
          // Only a pure expiry counts as a forced release.
          w_timeout_nxt = w_rel_max && !w_rel_done && !w_rel_req;
        end else begin
          w_hcnt_nxt = r_hcnt + HW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_grant   <= 8'h00;
      r_ptr     <= 3'd0;
      r_idx     <= 3'd0;
      r_hcnt    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_ptr     <= w_ptr_nxt;
      r_idx     <= w_idx_nxt;
      r_hcnt    <= w_hcnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign bus.grant   = r_grant;
  assign bus.busy    = |r_grant;
  assign bus.timeout = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter_8.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rr_arbiter_8 : directed + random checks of rr_arbiter_8 against a
//                   cycle-level round-robin reference model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_rr_arbiter_8;

  localparam int MAX_HOLD = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: holder index (-1 = none), rotation pointer,
  // number of cycles the current holder has been granted.
  int   m_holder;
  int   m_ptr;
  int   m_cycles;
  bit   m_to;

  rr_arbiter_8_if bus ();

  rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_grant();
    return (m_holder < 0) ? 8'h00 : 8'(1 << m_holder);
  endfunction

  task automatic model_reset();
    m_holder = -1;
    m_ptr    = 0;
    m_cycles = 0;
    m_to     = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] rq, input logic dn);
    m_to = 1'b0;
    if (m_holder < 0) begin
      for (int k = 0; k < 8; k++) begin
        if (m_holder < 0 && rq[(m_ptr + k) % 8]) begin
          m_holder = (m_ptr + k) % 8;
          m_cycles = 1;
        end
      end
    end else begin
      if (dn || !rq[m_holder] || m_cycles == MAX_HOLD) begin
        m_to     = (m_cycles == MAX_HOLD) && !dn && rq[m_holder];
        m_ptr    = (m_holder + 1) % 8;
        m_holder = -1;
      end else begin
        m_cycles++;
      end
    end
  endtask

  task automatic cyc(input logic [7:0] rq, input logic dn);
    bus.req  = rq;
    bus.done = dn;
    @(posedge clk);
    model_step(rq, dn);
    #1;
    check("grant",   32'(bus.grant),   32'(m_grant()));
    check("busy",    32'(bus.busy),    32'(m_holder >= 0));
    check("timeout", 32'(bus.timeout), 32'(m_to));
    check("onehot",  32'($countones(bus.grant) <= 1), 32'd1);
  endtask

  // Asserts reset away from any clock edge and checks outputs clear at once.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_grant",   32'(bus.grant),   32'h0);
    check("rst_busy",    32'(bus.busy),    32'h0);
    check("rst_timeout", 32'(bus.timeout), 32'h0);
    model_reset();
    #10;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] rq;
    logic [7:0] e;
    rst_n    = 1'b0;
    bus.req  = 8'h00;
    bus.done = 1'b0;
    model_reset();
    #3;
    check("por_grant",   32'(bus.grant),   32'h0);
    check("por_busy",    32'(bus.busy),    32'h0);
    check("por_timeout", 32'(bus.timeout), 32'h0);
    #20;
    rst_n = 1'b1;

    // Single requester, done after three grant cycles, then re-grant.
    cyc(8'h00, 1'b1);
    cyc(8'h01, 1'b0);
    cyc(8'h01, 1'b0);
    cyc(8'h01, 1'b0);
    cyc(8'h01, 1'b1);
    check("req027_gap", 32'(bus.grant), 32'h00);
    cyc(8'h01, 1'b0);
    check("req027_regrant", 32'(bus.grant), 32'h01);
    cyc(8'h00, 1'b0);

    // Full rotation from reset with done every grant cycle.
    async_reset();
    for (int i = 0; i < 8; i++) begin
      e = 8'h01 << i;
      cyc(8'hFF, 1'b1);
      check("rot_grant", 32'(bus.grant), 32'(e));
      cyc(8'hFF, 1'b1);
      check("rot_gap", 32'(bus.grant), 32'h00);
    end
    cyc(8'hFF, 1'b1);
    check("rot_wrap", 32'(bus.grant), 32'h01);
    cyc(8'h00, 1'b1);

    // Two requesters hogging: forced releases alternate 0 and 7.
    async_reset();
    for (int i = 0; i < 14; i++) cyc(8'h81, 1'b0);
    cyc(8'h00, 1'b0);

    // Holder 2 drops its request while 5 waits; unrelated req changes ignored.
    async_reset();
    cyc(8'h04, 1'b0);
    cyc(8'h24, 1'b0);
    cyc(8'h2C, 1'b0);
    cyc(8'h20, 1'b0);
    check("req030_rel_to", 32'(bus.timeout), 32'h0);
    cyc(8'h20, 1'b0);
    check("req030_next", 32'(bus.grant), 32'h20);
    cyc(8'h00, 1'b1);

    // done coincides with expiry: release without timeout.
    cyc(8'h01, 1'b0);
    for (int i = 0; i < MAX_HOLD - 1; i++) cyc(8'h01, 1'b0);
    cyc(8'h01, 1'b1);
    check("req032_to", 32'(bus.timeout), 32'h0);
    cyc(8'h00, 1'b0);

    // Async reset mid-hold on requester 4, then restart from ptr 0.
    cyc(8'h10, 1'b0);
    cyc(8'h10, 1'b0);
    check("req031_pre", 32'(bus.grant), 32'h10);
    async_reset();
    cyc(8'h10, 1'b0);
    check("req031_post", 32'(bus.grant), 32'h10);
    cyc(8'h00, 1'b0);

    // Random traffic with slowly varying request lines.
    rq = 8'($urandom);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3, 0) == 0) rq = rq ^ (8'h01 << $urandom_range(7, 0));
      if ($urandom_range(40, 0) == 0) rq = 8'($urandom);
      cyc(rq, ($urandom_range(5, 0) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rr_arbiter_8.md
RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 16: maximum consecutive cycles a single grant may be held, legal range 2..256.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req, input, 8 bits: request lines, bit i = requester i, any number may be high.
REQ-005 The block SHALL have port done, input, 1 bit: current grant holder finished, sampled only while busy=1.
REQ-006 The block SHALL have port grant, output, 8 bits: registered grant, all-zero or exactly one bit set, suitable for direct feed to the 8-to-3 one-hot encoder.
REQ-007 The block SHALL have port busy, output, 1 bit: high exactly when grant is non-zero.
REQ-008 The block SHALL have port timeout, output, 1 bit: one-cycle pulse marking a forced release.

Function
REQ-009 The block SHALL contain a 2-state FSM, IDLE and HOLD, a 3-bit priority pointer ptr, and a hold counter hcnt wide enough for MAX_HOLD-1.
REQ-010 In IDLE with req==0, the block SHALL stay in IDLE with grant=0 and ptr unchanged.
REQ-011 In IDLE with req!=0, the block SHALL select the first set bit searching circularly from index ptr upward (ptr, ptr+1, ... 7, 0, ...).
REQ-012 On the same IDLE edge, the block SHALL register the selected index one-hot into grant, clear hcnt, and enter HOLD.
REQ-013 The grant SHALL appear the cycle after req is first sampled high (latency 1).
REQ-014 In HOLD, grant SHALL stay constant while none of the release conditions in REQ-015 holds; hcnt SHALL increment by 1 each such cycle.
REQ-015 Release conditions, evaluated each HOLD edge: (a) done=1; (b) req bit of the holder is 0; (c) hcnt==MAX_HOLD-1.
REQ-016 On release, the block SHALL set grant=0, enter IDLE, and set ptr to (holder index + 1) mod 8, wrapping 7 to 0.
REQ-017 Timeout SHALL be 1 on the edge of release only when (c) holds and neither (a) nor (b) holds; timeout SHALL be 0 at all other times.
REQ-018 Exactly one all-zero grant cycle SHALL separate consecutive grants, including repeated grants to the same requester.
REQ-019 The holder SHALL be granted at most MAX_HOLD consecutive cycles.
REQ-020 Changes on req bits other than the holder's SHALL NOT affect grant during HOLD.
REQ-021 done asserted in IDLE SHALL be ignored.
REQ-022 grant SHALL never have more than one bit set in any cycle.
REQ-023 With all 8 requesters continuously requesting, grants SHALL rotate 0,1,...,7,0 from reset with no starvation.

Reset
REQ-024 While rst_n=0, the block SHALL hold grant=8'h00, busy=0, timeout=0, ptr=0, hcnt=0 and state IDLE, independent of clk.
REQ-025 Assertion of rst_n mid-HOLD SHALL clear grant immediately, with no timeout pulse.
REQ-026 After rst_n deasserts, the first arbitration SHALL occur on the first rising clk edge on which rst_n is sampled high.

Verification
REQ-027 Scenario: reset, then req=8'h01 held, done pulsed after 3 grant cycles -> grant=8'h01 for 3 cycles, then 8'h00 for one cycle, then 8'h01 again.
REQ-028 Scenario: req=8'hFF held, done pulsed each grant's 1st cycle -> grant sequence 01,00,02,00,04,...,80,00,01 (wrap 7 to 0).
REQ-029 Scenario: req=8'h81 held, ptr=0, no done, MAX_HOLD=4 -> grant=8'h01 for 4 cycles with timeout=1 on the release edge, then 8'h80 for 4 cycles with timeout, then 8'h01.
REQ-030 Scenario: holder 2 drops req[2] mid-grant while req[5] is high -> grant=0 next cycle, timeout=0, then grant=8'h20.
REQ-031 Scenario: rst_n pulled low asynchronously mid-HOLD with grant=8'h10 -> grant=0 and busy=0 before the next clk edge; after release, req=8'h10 grants 8'h10 with ptr restarted at 0.
REQ-032 Scenario: done and timeout condition coincide on the same edge -> release occurs, timeout stays 0.
